// File: rtl/rotation_pkg.sv
// Shared definitions for the rotation DMA engine: register map, encodings, FSM states, AHB constants.
package rotation_pkg;

    localparam logic [7:0] REG_SRC           = 8'h00;
    localparam logic [7:0] REG_DST           = 8'h04;
    localparam logic [7:0] REG_HEIGHT        = 8'h08;
    localparam logic [7:0] REG_WIDTH         = 8'h0C;
    localparam logic [7:0] REG_NEW_HEIGHT    = 8'h10;
    localparam logic [7:0] REG_NEW_WIDTH     = 8'h14;
    localparam logic [7:0] REG_MODE          = 8'h18;
    localparam logic [7:0] REG_DIRECTION     = 8'h1C;
    localparam logic [7:0] REG_START         = 8'h20;
    localparam logic [7:0] REG_SRESET        = 8'h24;
    localparam logic [7:0] REG_INTR_MASK     = 8'h28;
    localparam logic [7:0] REG_RAW_STATUS    = 8'h2C;
    localparam logic [7:0] REG_MASKED_STATUS = 8'h30;
    localparam logic [7:0] REG_INTR_CLEAR    = 8'h34;

    localparam logic [1:0] MODE_0   = 2'd0;
    localparam logic [1:0] MODE_90  = 2'd1;
    localparam logic [1:0] MODE_180 = 2'd2;
    localparam logic [1:0] MODE_270 = 2'd3;

    localparam logic DIR_CCW = 1'b0;
    localparam logic DIR_CW  = 1'b1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR_ADDR = 3'd4;
    localparam logic [2:0] ST_WR_DATA = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] height;
        logic [15:0] width;
        logic [1:0]  turn;
    } rot_cfg_t;

    // Counter-clockwise by MODE quarter turns equals clockwise by (4 - MODE) mod 4.
    function automatic logic [1:0] eff_turn(input logic [1:0] mode, input logic dir);
        return (dir == DIR_CW) ? mode : (2'd0 - mode);
    endfunction

    function automatic logic [31:0] pix_addr(input logic [31:0] base, input logic [15:0] row,
                                             input logic [15:0] col, input logic [15:0] width);
        return base + ((32'(row) * 32'(width) + 32'(col)) << 2);
    endfunction

endpackage

// File: rtl/rotation_regs.sv
// Register file, read mux and done interrupt for the rotation engine.
// Optional feature: ROTATION_DIRECTION_EN adds the DIRECTION register (CCW support).
module rotation_regs
    import rotation_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic        busy_i,
    input  logic        done_set_i,
    output logic [31:0] prdata_o,
    output rot_cfg_t    cfg_o,
    output logic        start_o,
    output logic        srst_o,
    output logic        intr_o
);

    logic        wr, rd;
    logic [31:0] src_q, dst_q, prdata_q, rdata;
    logic [15:0] height_q, width_q, new_h, new_w;
    logic [1:0]  mode_q, turn;
    logic        mask_q, raw_q;
`ifdef ROTATION_DIRECTION_EN
    logic        dir_q;
    assign turn = eff_turn(mode_q, dir_q);
`else
    assign turn = mode_q;
`endif

    assign wr      = psel_i & penable_i & pwrite_i;
    assign rd      = psel_i & penable_i & ~pwrite_i;
    assign srst_o  = wr && (paddr_i == REG_SRESET) && pwdata_i[0];
    assign start_o = wr && (paddr_i == REG_START) && pwdata_i[0] && !busy_i;
    assign new_h   = turn[0] ? width_q : height_q;
    assign new_w   = turn[0] ? height_q : width_q;

    always_comb begin
        rdata = '0;
        case (paddr_i)
            REG_SRC:           rdata = src_q;
            REG_DST:           rdata = dst_q;
            REG_HEIGHT:        rdata = {16'h0, height_q};
            REG_WIDTH:         rdata = {16'h0, width_q};
            REG_NEW_HEIGHT:    rdata = {16'h0, new_h};
            REG_NEW_WIDTH:     rdata = {16'h0, new_w};
            REG_MODE:          rdata = {30'h0, mode_q};
`ifdef ROTATION_DIRECTION_EN
            REG_DIRECTION:     rdata = {31'h0, dir_q};
`endif
            REG_START:         rdata = {31'h0, busy_i};
            REG_INTR_MASK:     rdata = {31'h0, mask_q};
            REG_RAW_STATUS:    rdata = {31'h0, raw_q};
            REG_MASKED_STATUS: rdata = {31'h0, raw_q & ~mask_q};
            default:           rdata = '0;
        endcase
    end

    // Soft reset clears exactly the same state as the hard reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            src_q <= '0; dst_q <= '0; height_q <= '0; width_q <= '0; mode_q <= '0;
            mask_q <= 1'b0; raw_q <= 1'b0; prdata_q <= '0;
`ifdef ROTATION_DIRECTION_EN
            dir_q <= 1'b0;
`endif
        end else if (srst_o) begin
            src_q <= '0; dst_q <= '0; height_q <= '0; width_q <= '0; mode_q <= '0;
            mask_q <= 1'b0; raw_q <= 1'b0; prdata_q <= '0;
`ifdef ROTATION_DIRECTION_EN
            dir_q <= 1'b0;
`endif
        end else begin
            if (wr && !busy_i) begin
                case (paddr_i)
                    REG_SRC:       src_q    <= pwdata_i;
                    REG_DST:       dst_q    <= pwdata_i;
                    REG_HEIGHT:    height_q <= pwdata_i[15:0];
                    REG_WIDTH:     width_q  <= pwdata_i[15:0];
                    REG_MODE:      mode_q   <= pwdata_i[1:0];
`ifdef ROTATION_DIRECTION_EN
                    REG_DIRECTION: dir_q    <= pwdata_i[0];
`endif
                    default: ;
                endcase
            end
            if (wr && (paddr_i == REG_INTR_MASK))
                mask_q <= pwdata_i[0];
            if (done_set_i)
                raw_q <= 1'b1;
            else if (wr && (paddr_i == REG_INTR_CLEAR) && pwdata_i[0])
                raw_q <= 1'b0;
            if (rd)
                prdata_q <= rdata;
        end
    end

    assign prdata_o = prdata_q;
    assign intr_o   = raw_q & ~mask_q;
    assign cfg_o    = '{src: src_q, dst: dst_q, height: height_q, width: width_q, turn: turn};

endmodule

// File: rtl/rotation.sv
// Image rotation DMA engine: APB register file plus single-beat AHB master copying rotated pixels.
// Optional feature: ROTATION_DIRECTION_EN (handled in rotation_regs) enables CCW rotation.
module rotation
    import rotation_pkg::*;
(
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic [31:0] I_REG_PADDR,
    input  logic [31:0] I_REG_PWDATA,
    input  logic        I_REG_PSEL,
    input  logic        I_REG_PENABLE,
    input  logic        I_REG_PWRITE,
    output logic [31:0] O_REG_PRDATA,
    output logic [31:0] O_DMA_HADDR,
    output logic [31:0] O_DMA_HWDATA,
    output logic [1:0]  O_DMA_HTRANS,
    output logic [2:0]  O_DMA_HSIZE,
    output logic [2:0]  O_DMA_HBURST,
    output logic        O_DMA_HBUSREQ,
    output logic        O_DMA_HWRITE,
    input  logic [31:0] I_DMA_HRDATA,
    input  logic        I_DMA_HGRANT,
    input  logic        I_DMA_HREADY,
    output logic        O_INTR_DONE
);

    // state      | meaning
    // IDLE       | waiting for START
    // REQ        | bus requested, waiting for grant
    // RD_ADDR    | read address phase of current pixel
    // RD_DATA    | read data phase, captures HRDATA
    // WR_ADDR    | write address phase at rotated position
    // WR_DATA    | write data phase, then next pixel or DONE
    // DONE       | raises RAW, returns to IDLE

    rot_cfg_t    cfg;
    logic        start, srst, busy, done_set, addr_ok, last_col, last_row;
    logic [2:0]  state_q, state_d;
    logic [15:0] row_q, row_d, col_q, col_d, wr_row, wr_col, new_w;
    logic [31:0] pix_q, pix_d, rd_addr, wr_addr;
    logic        unused_paddr;

    assign unused_paddr = ^I_REG_PADDR[31:8];

    rotation_regs u_regs (
        .clk_i      (I_HCLK),
        .rst_n_i    (I_HRESET_N),
        .paddr_i    (I_REG_PADDR[7:0]),
        .pwdata_i   (I_REG_PWDATA),
        .psel_i     (I_REG_PSEL),
        .penable_i  (I_REG_PENABLE),
        .pwrite_i   (I_REG_PWRITE),
        .busy_i     (busy),
        .done_set_i (done_set),
        .prdata_o   (O_REG_PRDATA),
        .cfg_o      (cfg),
        .start_o    (start),
        .srst_o     (srst),
        .intr_o     (O_INTR_DONE)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done_set = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign addr_ok  = I_DMA_HGRANT & I_DMA_HREADY;
    assign last_col = (col_q == cfg.width - 16'd1);
    assign last_row = (row_q == cfg.height - 16'd1);

    always_comb begin
        wr_row = row_q;
        wr_col = col_q;
        case (cfg.turn)
            MODE_90:  begin wr_row = col_q;                        wr_col = cfg.height - 16'd1 - row_q; end
            MODE_180: begin wr_row = cfg.height - 16'd1 - row_q;   wr_col = cfg.width - 16'd1 - col_q;  end
            MODE_270: begin wr_row = cfg.width - 16'd1 - col_q;    wr_col = row_q;                      end
            default:  begin wr_row = row_q;                        wr_col = col_q;                      end
        endcase
    end

    assign new_w   = cfg.turn[0] ? cfg.height : cfg.width;
    assign rd_addr = pix_addr(cfg.src, row_q, col_q, cfg.width);
    assign wr_addr = pix_addr(cfg.dst, wr_row, wr_col, new_w);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pix_d   = pix_q;
        case (state_q)
            ST_IDLE: if (start) begin
                row_d   = '0;
                col_d   = '0;
                state_d = (cfg.height == '0 || cfg.width == '0) ? ST_DONE : ST_REQ;
            end
            ST_REQ:     if (I_DMA_HGRANT) state_d = ST_RD_ADDR;
            ST_RD_ADDR: if (addr_ok) state_d = ST_RD_DATA;
            ST_RD_DATA: if (I_DMA_HREADY) begin
                pix_d   = I_DMA_HRDATA;
                state_d = ST_WR_ADDR;
            end
            ST_WR_ADDR: if (addr_ok) state_d = ST_WR_DATA;
            ST_WR_DATA: if (I_DMA_HREADY) begin
                if (!last_col) begin
                    col_d   = col_q + 16'd1;
                    state_d = ST_RD_ADDR;
                end else begin
                    col_d = '0;
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 16'd1;
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
        end else if (srst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
        end
    end

    assign O_DMA_HTRANS  = (state_q == ST_RD_ADDR || state_q == ST_WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign O_DMA_HWRITE  = (state_q == ST_WR_ADDR);
    assign O_DMA_HBUSREQ = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign O_DMA_HSIZE   = O_DMA_HBUSREQ ? HSIZE_WORD : 3'b000;
    assign O_DMA_HBURST  = HBURST_SINGLE;
    assign O_DMA_HWDATA  = pix_q;
    assign O_DMA_HADDR   = (state_q == ST_RD_ADDR || state_q == ST_RD_DATA) ? rd_addr :
                           (state_q == ST_WR_ADDR || state_q == ST_WR_DATA) ? wr_addr : 32'h0;

endmodule

// File: tb/tb_rotation.sv
// Self-checking bench for rotation: AHB slave model with address/data scoreboard plus register checks.
module tb_rotation;

    localparam logic [7:0] A_SRC = 8'h00, A_DST = 8'h04, A_H = 8'h08, A_W = 8'h0C;
    localparam logic [7:0] A_NH = 8'h10, A_NW = 8'h14, A_MODE = 8'h18, A_DIR = 8'h1C;
    localparam logic [7:0] A_START = 8'h20, A_SRST = 8'h24, A_MASK = 8'h28, A_RAW = 8'h2C;
    localparam logic [7:0] A_MSK_ST = 8'h30, A_CLR = 8'h34;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, hrdata = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, gnt = 1'b1, rdy = 1'b1;
    logic [31:0] prdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        hbusreq, hwrite, intr;

    always #5 clk = ~clk;

    rotation dut (
        .I_HCLK(clk), .I_HRESET_N(rst_n),
        .I_REG_PADDR(paddr), .I_REG_PWDATA(pwdata), .I_REG_PSEL(psel),
        .I_REG_PENABLE(penable), .I_REG_PWRITE(pwrite), .O_REG_PRDATA(prdata),
        .O_DMA_HADDR(haddr), .O_DMA_HWDATA(hwdata), .O_DMA_HTRANS(htrans),
        .O_DMA_HSIZE(hsize), .O_DMA_HBURST(hburst), .O_DMA_HBUSREQ(hbusreq),
        .O_DMA_HWRITE(hwrite), .I_DMA_HRDATA(hrdata), .I_DMA_HGRANT(gnt),
        .I_DMA_HREADY(rdy), .O_INTR_DONE(intr)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct {
        logic [15:0] h; logic [15:0] w; logic [1:0] mode; logic dir;
        logic [31:0] src; logic [31:0] dst; logic [31:0] exp_nh; logic [31:0] exp_nw; int exp_cyc;
    } vec_t;

    int          checks = 0, failures = 0, cyc = 0;
    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    logic [31:0] wlog[$];
    logic        wpend = 1'b0;
    wr_t         mon_e;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] addr);
        checks++;
        failures++;
        $display("FAIL %s actual_addr=0x%08h required=no_transfer", name, addr);
    endtask

    // AHB slave: check accepted address phases against the scoreboard, return read data, check write data.
    always @(negedge clk) if (rst_n) begin
        if (wpend && rdy) begin
            wpend = 1'b0;
            if (exp_wr.size() == 0) unexpected("wr_data", haddr);
            else begin
                mon_e = exp_wr.pop_front();
                chk("wr_data", hwdata, mon_e.data);
            end
        end
        if (htrans == 2'b10 && gnt && rdy) begin
            chk("hsize", {29'h0, hsize}, 32'h2);
            if (hwrite) begin
                wpend = 1'b1;
                wlog.push_back(haddr);
                if (exp_wr.size() == 0) unexpected("wr_addr", haddr);
                else chk("wr_addr", haddr, exp_wr[0].addr);
            end else begin
                if (exp_rd.size() == 0) unexpected("rd_addr", haddr);
                else chk("rd_addr", haddr, exp_rd.pop_front());
                hrdata = haddr ^ 32'h1A5;
            end
        end
    end

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        paddr = {24'h0, a}; pwdata = d; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
        paddr = {24'h0, a}; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        d = prdata;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic configure(input vec_t v);
        apb_wr(A_SRC, v.src);
        apb_wr(A_DST, v.dst);
        apb_wr(A_H, {16'h0, v.h});
        apb_wr(A_W, {16'h0, v.w});
        apb_wr(A_MODE, {30'h0, v.mode});
        apb_wr(A_DIR, {31'h0, v.dir});
    endtask

    task automatic push_model(input vec_t v);
        int k, nw, rr, cc, h, w;
        logic [31:0] ra;
        wr_t e;
        h = int'(v.h);
        w = int'(v.w);
`ifdef ROTATION_DIRECTION_EN
        k = v.dir ? int'(v.mode) : (4 - int'(v.mode)) % 4;
`else
        k = int'(v.mode);
`endif
        nw = (k % 2 == 1) ? h : w;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                case (k)
                    0:       begin rr = r;         cc = c;         end
                    1:       begin rr = c;         cc = h - 1 - r; end
                    2:       begin rr = h - 1 - r; cc = w - 1 - c; end
                    default: begin rr = w - 1 - c; cc = r;         end
                endcase
                ra = v.src + 32'(4 * (r * w + c));
                e.addr = v.dst + 32'(4 * (rr * nw + cc));
                e.data = ra ^ 32'h1A5;
                exp_rd.push_back(ra);
                exp_wr.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int t0, output int n);
        int lim = 0;
        while (!intr && lim < 300) begin
            @(posedge clk); #1;
            lim++;
        end
        if (!intr) unexpected("done_timeout", haddr);
        n = cyc - t0;
    endtask

    task automatic check_drained(input string name);
        chk({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic finish_run();
        apb_wr(A_CLR, 32'h1);
        chk("intr_cleared", {31'h0, intr}, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, output int n);
        configure(v);
        rd_chk("new_height", A_NH, v.exp_nh);
        rd_chk("new_width", A_NW, v.exp_nw);
        wlog.delete();
        push_model(v);
        apb_wr(A_START, 32'h1);
        wait_done(cyc, n);
        check_drained("run");
    endtask

    vec_t        tbl[6];
    vec_t        v;
    int          n, t0, seen;
    logic [31:0] saved;
    logic [31:0] log_a[$];
    wr_t         e1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'd2, 16'd3, 2'd1, 1'b1, 32'h0000_1000, 32'h0000_2000, 32'd3, 32'd2, 25};
        tbl[1] = '{16'd2, 16'd3, 2'd2, 1'b1, 32'h0000_1000, 32'h0000_3000, 32'd2, 32'd3, 25};
        tbl[2] = '{16'd3, 16'd2, 2'd3, 1'b1, 32'h0000_4000, 32'h0000_5000, 32'd2, 32'd3, 25};
        tbl[3] = '{16'd1, 16'd4, 2'd0, 1'b1, 32'hFFFF_FFF8, 32'h0000_6000, 32'd1, 32'd4, 17};
        tbl[4] = '{16'd0, 16'd3, 2'd1, 1'b1, 32'h0000_1000, 32'h0000_2000, 32'd3, 32'd0, 0};
        tbl[5] = '{16'd2, 16'd0, 2'd0, 1'b1, 32'h0000_1000, 32'h0000_2000, 32'd2, 32'd0, 0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_ahb_ctl", {24'h0, htrans, hsize, hburst}, 32'h0);
        chk("rst_busreq_hwrite_intr", {29'h0, hbusreq, hwrite, intr}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        rd_chk("rst_src", A_SRC, 32'h0);
        rd_chk("rst_height", A_H, 32'h0);
        rd_chk("rst_start", A_START, 32'h0);

        // 1x1 image, grant arrives one cycle late.
        v = '{16'd1, 16'd1, 2'd0, 1'b1, 32'h100, 32'h200, 32'd1, 32'd1, 6};
        configure(v);
        exp_rd.push_back(32'h100);
        e1.addr = 32'h200;
        e1.data = 32'hA5;
        exp_wr.push_back(e1);
        gnt = 1'b0;
        apb_wr(A_START, 32'h1);
        t0 = cyc;
        chk("busreq_after_start", {31'h0, hbusreq}, 32'h1);
        @(posedge clk); #1;
        gnt = 1'b1;
        wait_done(t0, n);
        chk("one_px_cycles", n, 32'd6);
        chk("one_px_intr", {31'h0, intr}, 32'h1);
        check_drained("one_px");
        rd_chk("one_px_raw", A_RAW, 32'h1);
        finish_run();

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], n);
            chk($sformatf("vec%0d_cycles", i), n, tbl[i].exp_cyc);
            if (i == 0) begin
                chk("r90_wlog_len", 32'(wlog.size()), 32'd6);
                if (wlog.size() == 6) begin
                    chk("r90_px00_addr", wlog[0], 32'h2004);
                    chk("r90_px12_addr", wlog[5], 32'h2010);
                end
            end
            finish_run();
        end

`ifdef ROTATION_DIRECTION_EN
        v = '{16'd2, 16'd3, 2'd1, 1'b0, 32'h1000, 32'h7000, 32'd3, 32'd2, 25};
        run_vec(v, n);
        rd_chk("direction_rd", A_DIR, 32'h0);
        finish_run();
        log_a = wlog;
        v = '{16'd2, 16'd3, 2'd3, 1'b1, 32'h1000, 32'h7000, 32'd3, 32'd2, 25};
        run_vec(v, n);
        finish_run();
        chk("ccw_log_len", 32'(wlog.size()), 32'(log_a.size()));
        for (int i = 0; i < wlog.size() && i < log_a.size(); i++)
            chk($sformatf("ccw_vs_cw270_%0d", i), log_a[i], wlog[i]);
`else
        apb_wr(A_DIR, 32'h1);
        rd_chk("direction_absent", A_DIR, 32'h0);
`endif

        // HREADY held low for three cycles in the first read data phase.
        v = '{16'd1, 16'd2, 2'd0, 1'b1, 32'h800, 32'h900, 32'd1, 32'd2, 12};
        configure(v);
        push_model(v);
        apb_wr(A_START, 32'h1);
        t0 = cyc;
        for (int lim = 0; lim < 20; lim++) begin
            if (htrans == 2'b10 && !hwrite) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_haddr", haddr, 32'h800);
            chk("stall_htrans", {30'h0, htrans}, 32'h0);
        end
        rdy = 1'b1;
        wait_done(t0, n);
        chk("stall_cycles", n, 32'd12);
        check_drained("stall");
        finish_run();

        // Masked completion, busy readback and write protection.
        apb_wr(A_MASK, 32'h1);
        v = '{16'd1, 16'd1, 2'd0, 1'b1, 32'h300, 32'h400, 32'd1, 32'd1, 5};
        configure(v);
        push_model(v);
        apb_wr(A_START, 32'h1);
        rd_chk("start_busy", A_START, 32'h1);
        apb_wr(A_H, 32'h5);
        repeat (10) @(posedge clk);
        #1;
        rd_chk("mask_raw", A_RAW, 32'h1);
        rd_chk("mask_masked", A_MSK_ST, 32'h0);
        chk("mask_intr", {31'h0, intr}, 32'h0);
        rd_chk("busy_write_ignored", A_H, 32'h1);
        apb_wr(A_CLR, 32'h1);
        rd_chk("clear_raw", A_RAW, 32'h0);
        apb_wr(A_MASK, 32'h0);
        check_drained("mask");
        apb_wr(8'h38, 32'hFFFF_FFFF);
        rd_chk("unmapped", 8'h38, 32'h0);

        // Soft reset in the second pixel's read address phase.
        v = '{16'd2, 16'd3, 2'd1, 1'b1, 32'hA00, 32'hB00, 32'd3, 32'd2, 25};
        configure(v);
        push_model(v);
        apb_wr(A_START, 32'h1);
        seen = 0;
        for (int lim = 0; lim < 60; lim++) begin
            if (htrans == 2'b10 && !hwrite) seen++;
            if (seen == 2) break;
            @(posedge clk); #1;
        end
        chk("srst_reached_px2", seen, 32'd2);
        apb_wr(A_SRST, 32'h1);
        chk("srst_busreq", {31'h0, hbusreq}, 32'h0);
        chk("srst_htrans", {30'h0, htrans}, 32'h0);
        exp_rd.delete();
        exp_wr.delete();
        wpend = 1'b0;
        rd_chk("srst_src", A_SRC, 32'h0);
        rd_chk("srst_dst", A_DST, 32'h0);
        rd_chk("srst_height", A_H, 32'h0);
        rd_chk("srst_width", A_W, 32'h0);
        rd_chk("srst_mode", A_MODE, 32'h0);
        rd_chk("srst_start", A_START, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("srst_quiet", {30'h0, htrans}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
